lp_filter_mc: RTL and testbench

- Time-multiplexed, multi-channel cascaded first-order IIR low-pass filter (exponential moving average).
- Each stage computes acc += (x - acc) >>> SHIFT. Per-channel, per-stage state is held internally, with extra fractional precision.
- The shift is selectable at runtime, per sample. The first sample on a channel warm-starts that channel.
- Sits after the multi-sensor period/frequency measurement mux and feeds the per-channel result registers.

---
 rtl/lp_filter_mc.sv | 126 ++++++++++++
 tb/tb_lp_filter_mc.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lp_filter_mc.sv
// Time-multiplexed multi-channel cascaded EMA low-pass filter.
// Per-channel, per-stage accumulators carry FRAC_BITS of extra precision; first sample per channel warm-starts.
module lp_filter_mc #(
    parameter int CHANNELS    = 4,
    parameter int DATA_BITS   = 28,
    parameter int FRAC_BITS   = 8,
    parameter int SHIFT_BITS  = 4,
    parameter int SHIFT_MAX   = 12,
    parameter int STAGE_COUNT = 4,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int A  = DATA_BITS + FRAC_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ce_i,
    input  logic                  clear_i,
    input  logic                  in_valid_i,
    input  logic [CW-1:0]         in_channel_i,
    input  logic [DATA_BITS-1:0]  in_value_i,
    input  logic [SHIFT_BITS-1:0] shift_i,
    output logic                  out_valid_o,
    output logic [CW-1:0]         out_channel_o,
    output logic [DATA_BITS-1:0]  out_value_o
);

    localparam logic [SHIFT_BITS-1:0] SMAX   = SHIFT_BITS'(SHIFT_MAX);
    localparam logic [CW:0]           CH_LIM = (CW + 1)'(CHANNELS);

    // element k holds the sample waiting at the input of stage k+1
    logic [STAGE_COUNT-1:0] p_valid_q;
    logic [STAGE_COUNT-1:0] p_warm_q;
    logic [CW-1:0]          p_ch_q  [STAGE_COUNT];
    logic [A-1:0]           p_x_q   [STAGE_COUNT];
    logic [SHIFT_BITS-1:0]  p_s_q   [STAGE_COUNT];

    logic [A-1:0]           acc_q   [STAGE_COUNT][CHANNELS];
    logic [CHANNELS-1:0]    primed_q;
    logic [CHANNELS-1:0]    primed_d;

    logic                   out_valid_q;
    logic [CW-1:0]          out_ch_q;
    logic [DATA_BITS-1:0]   out_val_q;

    logic                   accept;
    logic                   warm_in;
    logic [SHIFT_BITS-1:0]  s_in;

    logic [A-1:0]           acc_cur [STAGE_COUNT];
    logic signed [A:0]      diff    [STAGE_COUNT];
    logic signed [A:0]      step    [STAGE_COUNT];
    logic [A:0]             sum     [STAGE_COUNT];
    logic [A-1:0]           new_d   [STAGE_COUNT];

    always_comb begin
        accept   = in_valid_i && ({1'b0, in_channel_i} < CH_LIM);
        s_in     = (shift_i > SMAX) ? SMAX : shift_i;
        warm_in  = clear_i || !primed_q[in_channel_i];
        primed_d = clear_i ? '0 : primed_q;
        if (accept) begin
            primed_d[in_channel_i] = 1'b1;
        end
    end

    // the result always lies between acc and x, so the low A bits of the sum are exact
    always_comb begin
        for (int k = 0; k < STAGE_COUNT; k++) begin
            acc_cur[k] = acc_q[k][p_ch_q[k]];
            diff[k]    = $signed({1'b0, p_x_q[k]}) - $signed({1'b0, acc_cur[k]});
            step[k]    = diff[k] >>> p_s_q[k];
            sum[k]     = {1'b0, acc_cur[k]} + $unsigned(step[k]);
            new_d[k]   = p_warm_q[k] ? p_x_q[k] : sum[k][A-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p_valid_q   <= '0;
            p_warm_q    <= '0;
            primed_q    <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_val_q   <= '0;
            for (int k = 0; k < STAGE_COUNT; k++) begin
                p_ch_q[k] <= '0;
                p_x_q[k]  <= '0;
                p_s_q[k]  <= '0;
                for (int c = 0; c < CHANNELS; c++) begin
                    acc_q[k][c] <= '0;
                end
            end
        end else if (ce_i) begin
            primed_q     <= primed_d;
            p_valid_q[0] <= accept;
            if (accept) begin
                p_ch_q[0]   <= in_channel_i;
                p_x_q[0]    <= {in_value_i, {FRAC_BITS{1'b0}}};
                p_s_q[0]    <= s_in;
                p_warm_q[0] <= warm_in;
            end
            for (int k = 1; k < STAGE_COUNT; k++) begin
                p_valid_q[k] <= p_valid_q[k-1];
                if (p_valid_q[k-1]) begin
                    p_ch_q[k]   <= p_ch_q[k-1];
                    p_x_q[k]    <= new_d[k-1];
                    p_s_q[k]    <= p_s_q[k-1];
                    p_warm_q[k] <= p_warm_q[k-1];
                end
            end
            for (int k = 0; k < STAGE_COUNT; k++) begin
                if (p_valid_q[k]) begin
                    acc_q[k][p_ch_q[k]] <= new_d[k];
                end
            end
            out_valid_q <= p_valid_q[STAGE_COUNT-1];
            if (p_valid_q[STAGE_COUNT-1]) begin
                out_ch_q  <= p_ch_q[STAGE_COUNT-1];
                out_val_q <= new_d[STAGE_COUNT-1][A-1:FRAC_BITS];
            end
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_channel_o = out_ch_q;
    assign out_value_o   = out_val_q;

endmodule

// File: tb/tb_lp_filter_mc.sv
// Bench for lp_filter_mc: a 1-stage/16-bit instance and a default 4-stage/28-bit instance
// share stimulus and are checked against a per-sample arithmetic reference model.
module tb_lp_filter_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_channel = '0;
    logic [15:0] in_value1 = '0;
    logic [27:0] in_value4 = '0;
    logic [3:0]  shift = '0;

    logic        o_valid1, o_valid4;
    logic [1:0]  o_ch1, o_ch4;
    logic [15:0] o_val1;
    logic [27:0] o_val4;

    logic        ov_valid [2];
    logic [1:0]  oc [2];
    logic [63:0] ov [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lp_filter_mc #(.CHANNELS(4), .DATA_BITS(16), .FRAC_BITS(8), .SHIFT_BITS(4),
                   .SHIFT_MAX(12), .STAGE_COUNT(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .clear_i(clear),
        .in_valid_i(in_valid), .in_channel_i(in_channel), .in_value_i(in_value1),
        .shift_i(shift), .out_valid_o(o_valid1), .out_channel_o(o_ch1), .out_value_o(o_val1));

    lp_filter_mc #(.CHANNELS(4), .DATA_BITS(28), .FRAC_BITS(8), .SHIFT_BITS(4),
                   .SHIFT_MAX(12), .STAGE_COUNT(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .clear_i(clear),
        .in_valid_i(in_valid), .in_channel_i(in_channel), .in_value_i(in_value4),
        .shift_i(shift), .out_valid_o(o_valid4), .out_channel_o(o_ch4), .out_value_o(o_val4));

    always_comb begin
        ov_valid[0] = o_valid1;  oc[0] = o_ch1;  ov[0] = {48'd0, o_val1};
        ov_valid[1] = o_valid4;  oc[1] = o_ch4;  ov[1] = {36'd0, o_val4};
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0]  ch;
        logic [63:0] val;
        int          due;
    } exp_t;

    exp_t        q [2][$];
    longint      macc [2][4][4];
    bit          primed [4];
    int          nst [2] = '{1, 4};
    int          ecount = 0;
    bit          ce_edge = 1'b0;
    bit          exp_last_valid [2];
    logic [1:0]  exp_last_ch [2];
    logic [63:0] exp_last_val [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                q[d].delete();
                exp_last_valid[d] = 1'b0;
                exp_last_ch[d]    = '0;
                exp_last_val[d]   = '0;
                for (int c = 0; c < 4; c++)
                    for (int k = 0; k < 4; k++) macc[d][c][k] = 0;
            end
            for (int c = 0; c < 4; c++) primed[c] = 1'b0;
            ce_edge = 1'b0;
        end else begin
            ce_edge = ce;
            if (ce) begin
                int     s, ch;
                bit     warm;
                longint x;
                exp_t   e;
                ecount++;
                ch   = int'(in_channel);
                s    = (int'(shift) > 12) ? 12 : int'(shift);
                warm = clear || !primed[ch];
                if (clear) for (int c = 0; c < 4; c++) primed[c] = 1'b0;
                if (in_valid) begin
                    primed[ch] = 1'b1;
                    for (int d = 0; d < 2; d++) begin
                        x = (d == 0) ? longint'(in_value1) : longint'(in_value4);
                        x = x * 256;
                        for (int k = 0; k < nst[d]; k++) begin
                            if (warm) macc[d][ch][k] = x;
                            else      macc[d][ch][k] = macc[d][ch][k] + ((x - macc[d][ch][k]) >>> s);
                            x = macc[d][ch][k];
                        end
                        e.ch  = in_channel;
                        e.val = 64'(x / 256);
                        e.due = ecount + nst[d];
                        q[d].push_back(e);
                    end
                end
            end
        end
    end

    // Output monitor: every enabled edge must match the model's timing and values exactly.
    always @(negedge clk) begin
        if (!rst && ce_edge) begin
            for (int d = 0; d < 2; d++) begin
                bit due_now;
                due_now = (q[d].size() > 0) && (q[d][0].due == ecount);
                n_checks++;
                if (ov_valid[d] !== due_now) begin
                    $display("FAIL out_valid dut%0d edge %0d got %b want %b", d, ecount, ov_valid[d], due_now);
                end else if (due_now) begin
                    if (oc[d] !== q[d][0].ch || ov[d] !== q[d][0].val)
                        $display("FAIL out_sample dut%0d edge %0d got ch%0d/%0d want ch%0d/%0d",
                                 d, ecount, oc[d], ov[d], q[d][0].ch, q[d][0].val);
                    else n_pass++;
                end else begin
                    if (oc[d] !== exp_last_ch[d] || ov[d] !== exp_last_val[d])
                        $display("FAIL out_hold dut%0d edge %0d got ch%0d/%0d want ch%0d/%0d",
                                 d, ecount, oc[d], ov[d], exp_last_ch[d], exp_last_val[d]);
                    else n_pass++;
                end
                if (due_now) begin
                    exp_last_ch[d]  = q[d][0].ch;
                    exp_last_val[d] = q[d][0].val;
                    void'(q[d].pop_front());
                end
                exp_last_valid[d] = due_now;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input bit v, input int ch, input logic [27:0] val, input int sh, input bit clr);
        in_valid   = v;
        in_channel = ch[1:0];
        in_value4  = val;
        in_value1  = val[15:0];
        shift      = sh[3:0];
        clear      = clr;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 28'd0, 0, 1'b0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #3;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (ov_valid[d] !== 1'b0 || oc[d] !== 2'd0 || ov[d] !== 64'd0)
                $display("FAIL reset_state dut%0d got v%b ch%0d val%0d want v0 ch0 val0", d, ov_valid[d], oc[d], ov[d]);
            else n_pass++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_warm_start();
        logic [63:0] want [3] = '{64'd1000, 64'd1250, 64'd1437};
        cycle(1'b1, 0, 28'd1000, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i < 2) cycle(1'b1, 0, 28'd2000, 2, 1'b0);
            else       idle(1);
            n_checks++;
            if (ov_valid[0] !== 1'b1 || oc[0] !== 2'd0 || ov[0] !== want[i])
                $display("FAIL warm_start[%0d] got v%b ch%0d val%0d want v1 ch0 val%0d", i, ov_valid[0], oc[0], ov[0], want[i]);
            else n_pass++;
        end
        idle(5);
    endtask

    task automatic test_independence();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, (i % 2 == 0) ? 1 : 2, (i % 2 == 0) ? 28'd100 : 28'd5000, int'($urandom_range(0, 15)), 1'b0);
            for (int d = 0; d < 2; d++) begin
                if (ov_valid[d]) begin
                    logic [63:0] w;
                    w = (oc[d] == 2'd2) ? 64'd5000 : 64'd100;
                    n_checks++;
                    if (ov[d] !== w)
                        $display("FAIL independence dut%0d ch%0d got %0d want %0d", d, oc[d], ov[d], w);
                    else n_pass++;
                end
            end
        end
        idle(5);
    endtask

    task automatic test_shift_clamp();
        logic [27:0] v;
        cycle(1'b1, 3, 28'd0, 15, 1'b0);
        cycle(1'b1, 3, 28'd4096, 15, 1'b0);
        idle(1);
        n_checks++;
        if (ov_valid[0] !== 1'b1 || ov[0] !== 64'd1)
            $display("FAIL shift_clamp got v%b val%0d want v1 val1", ov_valid[0], ov[0]);
        else n_pass++;
        idle(4);
        v = 28'($urandom);
        cycle(1'b1, 3, v, 0, 1'b0);
        idle(1);
        n_checks++;
        if (ov_valid[0] !== 1'b1 || ov[0] !== {48'd0, v[15:0]})
            $display("FAIL shift_bypass dut0 got %0d want %0d", ov[0], v[15:0]);
        else n_pass++;
        idle(3);
        n_checks++;
        if (ov_valid[1] !== 1'b1 || ov[1] !== {36'd0, v})
            $display("FAIL shift_bypass dut1 got %0d want %0d", ov[1], v);
        else n_pass++;
        idle(3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), 28'($urandom),
                  int'($urandom_range(0, 15)), $urandom_range(0, 24) == 0);
        end
        idle(6);
    endtask

    task automatic test_ce_freeze();
        for (int i = 0; i < 6; i++)
            cycle(1'b1, int'($urandom_range(0, 3)), 28'($urandom), int'($urandom_range(0, 15)), 1'b0);
        ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, int'($urandom_range(0, 3)), 28'($urandom), int'($urandom_range(0, 15)), 1'b0);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (ov_valid[d] !== exp_last_valid[d] || oc[d] !== exp_last_ch[d] || ov[d] !== exp_last_val[d])
                    $display("FAIL ce_freeze dut%0d got v%b ch%0d val%0d want v%b ch%0d val%0d", d,
                             ov_valid[d], oc[d], ov[d], exp_last_valid[d], exp_last_ch[d], exp_last_val[d]);
                else n_pass++;
            end
        end
        ce = 1'b1;
        for (int i = 0; i < 8; i++)
            cycle(1'b1, int'($urandom_range(0, 3)), 28'($urandom), int'($urandom_range(0, 15)), 1'b0);
        idle(6);
    endtask

    task automatic test_clear();
        cycle(1'b1, 0, 28'd1000, 0, 1'b0);
        cycle(1'b1, 0, 28'd1000, 3, 1'b0);
        cycle(1'b1, 0, 28'd1000, 3, 1'b0);
        cycle(1'b1, 0, 28'd3000, 3, 1'b1);
        cycle(1'b1, 3, 28'd500, 3, 1'b0);
        n_checks++;
        if (ov_valid[0] !== 1'b1 || oc[0] !== 2'd0 || ov[0] !== 64'd3000)
            $display("FAIL clear_warm got v%b ch%0d val%0d want v1 ch0 val3000", ov_valid[0], oc[0], ov[0]);
        else n_pass++;
        idle(1);
        n_checks++;
        if (ov_valid[0] !== 1'b1 || oc[0] !== 2'd3 || ov[0] !== 64'd500)
            $display("FAIL clear_other got v%b ch%0d val%0d want v1 ch3 val500", ov_valid[0], oc[0], ov[0]);
        else n_pass++;
        idle(5);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++)
            cycle(1'b1, int'($urandom_range(0, 3)), 28'($urandom), int'($urandom_range(1, 15)), 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (ov_valid[d] !== 1'b0 || oc[d] !== 2'd0 || ov[d] !== 64'd0)
                $display("FAIL async_reset dut%0d got v%b ch%0d val%0d want v0 ch0 val0", d, ov_valid[d], oc[d], ov[d]);
            else n_pass++;
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(6);
        cycle(1'b1, 1, 28'd777, 4, 1'b0);
        idle(1);
        n_checks++;
        if (ov_valid[0] !== 1'b1 || oc[0] !== 2'd1 || ov[0] !== 64'd777)
            $display("FAIL post_reset_warm got v%b ch%0d val%0d want v1 ch1 val777", ov_valid[0], oc[0], ov[0]);
        else n_pass++;
        idle(6);
    endtask

    initial begin
        test_reset();
        test_warm_start();
        test_independence();
        test_shift_clamp();
        test_random();
        test_ce_freeze();
        test_clear();
        test_async_reset();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (q[d].size() != 0)
                $display("FAIL drain dut%0d got %0d outstanding samples want 0", d, q[d].size());
            else n_pass++;
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
